// File: rtl/multicycle_core.sv
// Parametrised multi-cycle core: fetch/decode/execute/memory/writeback FSM
// with req/ack handshaked instruction and data memories outside the core.
module multicycle_core #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 2,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 4 + 2 * REG_AW
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic               overflow,
  output logic               retire,
  output logic               halted
);

  localparam int NREG = 2 ** REG_AW;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4, OP_SLT = 4'h5, OP_LW  = 4'h6, OP_SW  = 4'h7;
  localparam logic [3:0] OP_LI  = 4'h8, OP_SHL = 4'h9, OP_J   = 4'hA, OP_NOP = 4'hB;
  localparam logic [3:0] OP_BEQ = 4'hC, OP_BNE = 4'hD, OP_JAL = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              state_r, next_state_s;
  logic [INSTR_W-1:0]  ir_r;
  logic [3:0]          opcode_s;
  logic [REG_AW-1:0]   ra_s, rb_s;
  logic [DATA_W-1:0]   regs_r [NREG];
  logic [DATA_W-1:0]   op_a_r, op_b_r, op_z_r, result_r, mem_data_r, alu_s;
  logic [PC_W-1:0]     pc_r, target_r, target_s, pc_inc_s, branch_off_s;
  logic                jump_r, jump_s, ovf_s, overflow_r;
  logic                imem_req_r, dmem_req_r, dmem_we_r, retire_r, halted_r;
  logic                imem_req_d_s, dmem_req_d_s, dmem_we_d_s, retire_d_s, halted_d_s;

  function automatic logic add_ovf(input logic [DATA_W-1:0] a, b, s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic [DATA_W-1:0] a, b, s);
    return (a[DATA_W-1] != b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_LW, OP_LI, OP_SHL, OP_JAL: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  assign opcode_s     = ir_r[INSTR_W-1 -: 4];
  assign ra_s         = ir_r[2*REG_AW-1 -: REG_AW];
  assign rb_s         = ir_r[REG_AW-1:0];
  assign pc_inc_s     = pc_r + PC_W'(1'b1);
  // R[0] is a signed branch offset, sign-extended or truncated to the pc width
  assign branch_off_s = PC_W'($signed(op_z_r));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= next_state_s;
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH:  if (imem_req_r && imem_ack) next_state_s = S_DECODE;
                else                        next_state_s = S_FETCH;
      S_DECODE: next_state_s = S_EXEC;
      S_EXEC: begin
        case (opcode_s)
          OP_LW, OP_SW: next_state_s = S_MEM;
          OP_HLT:       next_state_s = S_HALT;
          default:      next_state_s = S_WB;
        endcase
      end
      S_MEM:    if (dmem_req_r && dmem_ack) next_state_s = S_WB;
                else                        next_state_s = S_MEM;
      S_WB:     next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Output logic: next values of the registered outputs, decided by the state being entered
  always_comb begin
    imem_req_d_s = (next_state_s == S_FETCH);
    dmem_req_d_s = (next_state_s == S_MEM);
    dmem_we_d_s  = (next_state_s == S_MEM) && (opcode_s == OP_SW);
    retire_d_s   = (next_state_s == S_WB) || ((state_r == S_EXEC) && (next_state_s == S_HALT));
    halted_d_s   = (next_state_s == S_HALT);
  end

  // Registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      dmem_we_r  <= 1'b0;
      retire_r   <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      imem_req_r <= imem_req_d_s;
      dmem_req_r <= dmem_req_d_s;
      dmem_we_r  <= dmem_we_d_s;
      retire_r   <= retire_d_s;
      halted_r   <= halted_d_s;
    end
  end

  // ALU and branch/jump evaluation on the DECODE-time operands
  always_comb begin
    alu_s    = '0;
    ovf_s    = 1'b0;
    jump_s   = 1'b0;
    target_s = pc_inc_s;
    case (opcode_s)
      OP_ADD: begin alu_s = op_a_r + op_b_r; ovf_s = add_ovf(op_a_r, op_b_r, alu_s); end
      OP_SUB: begin alu_s = op_a_r - op_b_r; ovf_s = sub_ovf(op_a_r, op_b_r, alu_s); end
      OP_AND: alu_s = op_a_r & op_b_r;
      OP_OR:  alu_s = op_a_r | op_b_r;
      OP_XOR: alu_s = op_a_r ^ op_b_r;
      OP_SLT: alu_s = ($signed(op_a_r) < $signed(op_b_r)) ? DATA_W'(1'b1) : '0;
      OP_LI:  alu_s = DATA_W'(rb_s);
      OP_SHL: alu_s = op_a_r << 1;
      OP_J:   begin jump_s = 1'b1; target_s = PC_W'(op_b_r); end
      OP_BEQ, OP_BNE: begin
        if ((op_a_r == op_b_r) == (opcode_s == OP_BEQ)) begin
          jump_s   = 1'b1;
          target_s = pc_r + branch_off_s;
        end else begin
          jump_s   = 1'b0;
          target_s = pc_inc_s;
        end
      end
      OP_JAL: begin alu_s = DATA_W'(pc_inc_s); jump_s = 1'b1; target_s = PC_W'(op_b_r); end
      default: alu_s = '0;
    endcase
  end

  // Datapath: instruction/operand latches, register file, pc and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_r       <= '0;
      op_a_r     <= '0;
      op_b_r     <= '0;
      op_z_r     <= '0;
      result_r   <= '0;
      mem_data_r <= '0;
      target_r   <= '0;
      jump_r     <= 1'b0;
      pc_r       <= '0;
      overflow_r <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
    end else begin
      case (state_r)
        S_FETCH: if (imem_req_r && imem_ack) ir_r <= imem_rdata;
        S_DECODE: begin
          op_a_r <= regs_r[ra_s];
          op_b_r <= regs_r[rb_s];
          op_z_r <= regs_r[0];
        end
        S_EXEC: begin
          result_r <= alu_s;
          jump_r   <= jump_s;
          target_r <= target_s;
          if (ovf_s) overflow_r <= 1'b1;
        end
        S_MEM: if (dmem_req_r && dmem_ack && !dmem_we_r) mem_data_r <= dmem_rdata;
        S_WB: begin
          if (writes_reg(opcode_s)) regs_r[ra_s] <= (opcode_s == OP_LW) ? mem_data_r : result_r;
          pc_r <= jump_r ? target_r : pc_inc_s;
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = op_b_r;
  assign dmem_wdata = op_a_r;
  assign pc         = pc_r;
  assign overflow   = overflow_r;
  assign retire     = retire_r;
  assign halted     = halted_r;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs in a bench-side imem,
// a dmem model with programmable ack latency, hand-computed expectations.
module tb_multicycle_core;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, OR_ = 4'h3, LW = 4'h6, SW = 4'h7;
  localparam logic [3:0] LI = 4'h8, SHL = 4'h9, J = 4'hA, NOP = 4'hB;
  localparam logic [3:0] BEQ = 4'hC, BNE = 4'hD, JAL = 4'hE, HLT = 4'hF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [7:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic       overflow, retire, halted;

  logic [7:0] imem [256];
  logic [7:0] dmem [256];
  logic       dmem_clr = 1'b0;
  int         dmem_wait = 0;
  int         dcnt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  multicycle_core #(.DATA_W(8), .REG_AW(2), .PC_W(8), .INSTR_W(8)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .overflow(overflow), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (!dmem_req || dmem_ack) dcnt <= 0;
    else                       dcnt <= dcnt + 1;
    if (reset && dmem_clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
    end else if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  function automatic logic [7:0] enc(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb);
    return {op, ra, rb};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = enc(HLT, 2'd0, 2'd0);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    dmem_clr = 1'b1;
    repeat (2) @(negedge clk);
    dmem_clr = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string name);
    for (int c = 0; c < budget && halted !== 1'b1; c++) @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout halted=%b required 1", name, halted);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_prog();
    repeat (2) @(negedge clk);
    checks += 7;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %b want 0", imem_req); end
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req got %b want 0", dmem_req); end
    if (dmem_we  !== 1'b0) begin errors++; $display("FAIL rst_dmem_we got %b want 0", dmem_we); end
    if (pc !== 8'h00)      begin errors++; $display("FAIL rst_pc got %h want 00", pc); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    if (retire !== 1'b0)   begin errors++; $display("FAIL rst_retire got %b want 0", retire); end
    if (halted !== 1'b0)   begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
  endtask

  // li R1,3; li R2,2; add R1,R2; sw R1,[R0]: retires at 4/8/12, sw at 17
  task automatic test_alu_basic();
    int rc [4];
    int n = 0;
    int exp_rc [4] = '{4, 8, 12, 17};
    clear_prog();
    imem[0] = enc(LI, 2'd1, 2'd3);
    imem[1] = enc(LI, 2'd2, 2'd2);
    imem[2] = enc(ADD, 2'd1, 2'd2);
    imem[3] = enc(SW, 2'd1, 2'd0);
    dmem_wait = 0;
    apply_reset();
    for (int c = 0; c < 60 && halted !== 1'b1; c++) begin
      @(negedge clk);
      if (retire === 1'b1 && n < 4) begin rc[n] = cyc; n++; end
      if (cyc == 13) begin
        checks++;
        if (pc !== 8'h03) begin errors++; $display("FAIL alu_pc3 got %h want 03", pc); end
      end
    end
    wait_halt(10, "alu");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= n || rc[k] != exp_rc[k]) begin
        errors++;
        $display("FAIL alu_retire_cycle[%0d] got %0d want %0d", k, (k < n) ? rc[k] : -1, exp_rc[k]);
      end
    end
    checks++;
    if (dmem[0] !== 8'h05) begin errors++; $display("FAIL alu_add_result got %h want 05", dmem[0]); end
  endtask

  task automatic test_overflow();
    clear_prog();
    imem[0] = enc(LI, 2'd1, 2'd3);
    for (int i = 1; i <= 5; i++) imem[i] = enc(SHL, 2'd1, 2'd0);
    imem[6] = enc(LI, 2'd2, 2'd3);
    for (int i = 7; i <= 11; i++) imem[i] = enc(SHL, 2'd2, 2'd0);
    imem[12] = enc(ADD, 2'd1, 2'd2);
    imem[13] = enc(SW, 2'd1, 2'd0);
    imem[14] = enc(LI, 2'd1, 2'd2);
    imem[15] = enc(LI, 2'd2, 2'd1);
    imem[16] = enc(SUB, 2'd1, 2'd2);
    imem[17] = enc(LI, 2'd3, 2'd1);
    imem[18] = enc(SW, 2'd1, 2'd3);
    dmem_wait = 0;
    apply_reset();
    for (int c = 0; c < 200 && pc !== 8'd12; c++) @(negedge clk);
    checks++;
    if (pc !== 8'd12 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before_add pc=%h ovf=%b want pc=0c ovf=0", pc, overflow);
    end
    wait_halt(200, "ovf");
    checks += 3;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    if (dmem[0] !== 8'hC0) begin errors++; $display("FAIL ovf_sum got %h want c0", dmem[0]); end
    if (dmem[1] !== 8'h01) begin errors++; $display("FAIL ovf_sub got %h want 01", dmem[1]); end
  endtask

  // Build R1=0x5A, R2=0x10; sw R1,[R2] with 3 wait cycles; lw R3,[R2]; sw R3,[R0]
  task automatic test_mem_wait();
    int sw_cycles = 0;
    logic [7:0] prog [18];
    prog = '{enc(LI,2'd1,2'd2), enc(SHL,2'd1,2'd0), enc(SHL,2'd1,2'd0), enc(LI,2'd3,2'd3),
             enc(OR_,2'd1,2'd3), enc(SHL,2'd1,2'd0), enc(SHL,2'd1,2'd0), enc(SHL,2'd1,2'd0),
             enc(LI,2'd3,2'd2), enc(OR_,2'd1,2'd3), enc(LI,2'd2,2'd2), enc(SHL,2'd2,2'd0),
             enc(SHL,2'd2,2'd0), enc(SHL,2'd2,2'd0), enc(SW,2'd1,2'd2), enc(LW,2'd3,2'd2),
             enc(SW,2'd3,2'd0), enc(HLT,2'd0,2'd0)};
    clear_prog();
    for (int i = 0; i < 18; i++) imem[i] = prog[i];
    dmem_wait = 3;
    apply_reset();
    for (int c = 0; c < 300 && halted !== 1'b1; c++) begin
      @(negedge clk);
      if (dmem_req === 1'b1 && pc == 8'd14) begin
        sw_cycles++;
        checks++;
        if (dmem_we !== 1'b1 || dmem_addr !== 8'h10 || dmem_wdata !== 8'h5A) begin
          errors++;
          $display("FAIL sw_bus we=%b addr=%h wdata=%h want 1/10/5a", dmem_we, dmem_addr, dmem_wdata);
        end
      end
      if (dmem_req === 1'b1 && pc == 8'd15) begin
        checks++;
        if (dmem_we !== 1'b0 || dmem_addr !== 8'h10) begin
          errors++;
          $display("FAIL lw_bus we=%b addr=%h want 0/10", dmem_we, dmem_addr);
        end
      end
    end
    wait_halt(10, "mem");
    checks += 3;
    if (sw_cycles != 4)     begin errors++; $display("FAIL sw_req_cycles got %0d want 4", sw_cycles); end
    if (dmem[16] !== 8'h5A) begin errors++; $display("FAIL sw_data got %h want 5a", dmem[16]); end
    if (dmem[0] !== 8'h5A)  begin errors++; $display("FAIL lw_data got %h want 5a", dmem[0]); end
    dmem_wait = 0;
  endtask

  task automatic test_branch();
    int n = 0;
    logic [7:0] exp_pc [12];
    exp_pc = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd6};
    clear_prog();
    imem[0] = enc(LI, 2'd1, 2'd1);
    imem[1] = enc(SUB, 2'd0, 2'd1);
    imem[2] = enc(SUB, 2'd0, 2'd1);
    imem[3] = enc(SUB, 2'd2, 2'd1);
    imem[4] = enc(NOP, 2'd0, 2'd0);
    imem[5] = enc(BNE, 2'd2, 2'd0);
    imem[6] = enc(NOP, 2'd0, 2'd0);
    imem[7] = enc(NOP, 2'd0, 2'd0);
    imem[8] = enc(BEQ, 2'd1, 2'd1);
    apply_reset();
    for (int c = 0; c < 300 && n < 12; c++) begin
      @(negedge clk);
      if (retire === 1'b1) begin
        @(negedge clk);
        checks++;
        if (pc !== exp_pc[n]) begin errors++; $display("FAIL branch_pc[%0d] got %h want %h", n, pc, exp_pc[n]); end
        n++;
      end
    end
    checks++;
    if (n != 12) begin errors++; $display("FAIL branch_timeout retired %0d want 12", n); end
  endtask

  task automatic test_pc_wrap();
    int n = 0;
    logic [7:0] exp_pc [4];
    exp_pc = '{8'h01, 8'h02, 8'hFF, 8'h00};
    clear_prog();
    imem[0]   = enc(LI, 2'd1, 2'd1);
    imem[1]   = enc(SUB, 2'd0, 2'd1);
    imem[2]   = enc(J, 2'd0, 2'd0);
    imem[255] = enc(NOP, 2'd0, 2'd0);
    apply_reset();
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      if (retire === 1'b1) begin
        @(negedge clk);
        checks++;
        if (pc !== exp_pc[n]) begin errors++; $display("FAIL wrap_pc[%0d] got %h want %h", n, pc, exp_pc[n]); end
        n++;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL wrap_timeout retired %0d want 4", n); end
  endtask

  // jal R2,R2 at pc 7 with R2=0x20, then sw R2,[R0] and halt at 0x21
  task automatic test_jal_halt();
    int nret = 0;
    clear_prog();
    imem[0] = enc(LI, 2'd2, 2'd2);
    for (int i = 1; i <= 4; i++) imem[i] = enc(SHL, 2'd2, 2'd0);
    imem[5] = enc(NOP, 2'd0, 2'd0);
    imem[6] = enc(NOP, 2'd0, 2'd0);
    imem[7] = enc(JAL, 2'd2, 2'd2);
    imem[8'h20] = enc(SW, 2'd2, 2'd0);
    apply_reset();
    for (int c = 0; c < 200 && halted !== 1'b1; c++) begin
      @(negedge clk);
      if (retire === 1'b1) nret++;
    end
    wait_halt(10, "jal");
    checks += 2;
    if (pc !== 8'h21)      begin errors++; $display("FAIL jal_target_pc got %h want 21", pc); end
    if (dmem[0] !== 8'h08) begin errors++; $display("FAIL jal_link got %h want 08", dmem[0]); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (retire === 1'b1) nret++;
      checks++;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h21) begin
        errors++;
        $display("FAIL halt_hold[%0d] imem_req=%b dmem_req=%b halted=%b pc=%h", c, imem_req, dmem_req, halted, pc);
      end
    end
    checks++;
    if (nret != 10) begin errors++; $display("FAIL halt_retire_count got %0d want 10", nret); end
  endtask

  task automatic test_abort();
    int nst = 0;
    logic seen_fetch = 1'b0;
    clear_prog();
    imem[0] = enc(LI, 2'd1, 2'd3);
    imem[1] = enc(LI, 2'd2, 2'd2);
    imem[2] = enc(LI, 2'd3, 2'd1);
    imem[3] = enc(SW, 2'd1, 2'd2);
    dmem_wait = 10;
    apply_reset();
    for (int c = 0; c < 100 && dmem_req !== 1'b1; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL abort_in_mem dmem_req=%b want 1", dmem_req); end
    #1 reset = 1'b1;
    #1;
    checks += 3;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL abort_dmem_req got %b want 0", dmem_req); end
    if (pc !== 8'h00)      begin errors++; $display("FAIL abort_pc got %h want 00", pc); end
    if (dmem_we !== 1'b0)  begin errors++; $display("FAIL abort_dmem_we got %b want 0", dmem_we); end
    dmem_wait = 0;
    clear_prog();
    imem[0] = enc(SW, 2'd1, 2'd2);
    imem[1] = enc(SW, 2'd3, 2'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 100 && halted !== 1'b1; c++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && !seen_fetch) begin
        seen_fetch = 1'b1;
        checks++;
        if (imem_addr !== 8'h00) begin errors++; $display("FAIL abort_refetch addr got %h want 00", imem_addr); end
      end
      if (dmem_req === 1'b1) begin
        nst++;
        checks++;
        if (dmem_addr !== 8'h00 || dmem_wdata !== 8'h00) begin
          errors++;
          $display("FAIL abort_regs_zero addr=%h wdata=%h want 00/00", dmem_addr, dmem_wdata);
        end
      end
    end
    wait_halt(10, "abort");
    checks += 2;
    if (nst != 2)          begin errors++; $display("FAIL abort_store_count got %0d want 2", nst); end
    if (dmem[2] !== 8'h00) begin errors++; $display("FAIL abort_no_write got %h want 00", dmem[2]); end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_overflow();
    test_mem_wait();
    test_branch();
    test_pc_wrap();
    test_jal_halt();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
Parametrised multi-cycle CPU core, the successor to the fixed 8-bit, 4-register sequencer. Clocked FSM: fetch, decode, execute, memory, writeback.
- Configurable data width, register count and PC width.
- Instruction and data memories sit outside the core, behind req/ack handshakes, so wait states are tolerated.
- Adds halt, jal link, overflow flag and a retire pulse.

Parameters:
DATA_W, 8, register/ALU/data-memory word width (>=8)
REG_AW, 2, register address width; register count = 2**REG_AW
PC_W, 8, program counter / instruction address width
INSTR_W, 4+2*REG_AW, instruction width: [INSTR_W-1 -: 4]=opcode, then ra field, then rb field (LSBs)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_rdata  in  INSTR_W  instruction word, valid when imem_ack
imem_ack  in  1  fetch complete
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  DATA_W  data address (= R[rb])
dmem_wdata  out  DATA_W  store data (= R[ra])
dmem_rdata  in  DATA_W  load data, valid when dmem_ack
dmem_ack  in  1  data access complete
pc  out  PC_W  current program counter
overflow  out  1  sticky signed overflow from add/sub
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  core in HALT

Behaviour:
- Reset (async, immediate): state=FETCH, pc=0, all registers=0, imem_req=dmem_req=dmem_we=0, overflow=0, retire=0, halted=0.
- Reset mid-operation aborts any instruction in flight. Nothing is written after reset asserts.
- FETCH:
  - imem_req=1 held until imem_ack.
  - On the ack cycle, latch imem_rdata into the instruction register and go to DECODE.
  - Minimum 1 cycle; any number of wait cycles allowed.
- DECODE: read R[ra], R[rb] and R[0] into operand registers. 1 cycle, then EXEC.
- EXEC: ALU/branch evaluation, 1 cycle. Next state is MEM for lw/sw, HALT for halt, WB for everything else.
- Opcodes:
  - 0000 add: R[ra]=R[ra]+R[rb]
  - 0001 sub: R[ra]=R[ra]-R[rb]
  - 0010 and; 0011 or; 0100 xor
  - 0101 slt: signed compare, result 1 or 0
  - 0110 lw: R[ra]=dmem[R[rb]]
  - 0111 sw: dmem[R[rb]]=R[ra]
  - 1000 li: R[ra]=zero-extended rb field
  - 1001 shl: R[ra]=R[ra]<<1
  - 1010 j: pc=R[rb][PC_W-1:0]
  - 1011 nop
  - 1100 beq / 1101 bne: if taken, pc=pc+R[0] (signed offset truncated/sign-extended to PC_W, wraps mod 2**PC_W); else pc+1
  - 1110 jal: R[ra]=pc+1 (zero-extended); pc=R[rb][PC_W-1:0]
  - 1111 halt
- Arithmetic: all results are mod 2**DATA_W. overflow sets on signed overflow of add/sub and stays set until reset.
- MEM:
  - dmem_req=1 (dmem_we=1 for sw) held with stable addr/wdata until dmem_ack.
  - lw latches dmem_rdata on the ack cycle. Then WB.
- WB:
  - Write R[ra] when the opcode writes a register.
  - pc update: pc+1 (wrap mod 2**PC_W) unless a jump or taken branch applies.
  - retire=1 for this single cycle; next state FETCH.
- Register-file ordering:
  - jal with ra==rb: the jump target uses the value read in DECODE, before the link is written.
  - Branch with ra==rb or ra==0: uses DECODE-time values.
- HALT:
  - halted=1, retire pulses once on entry, pc is not advanced.
  - Stays in HALT until reset; imem_req=dmem_req=0.
- Outputs: registered; req signals are never combinationally dependent on ack.
- Minimum CPI: 4 cycles (ALU ops, 0 wait), 5 cycles (lw/sw).

Test Plan:
- li R1=3; li R2=2; add R1,R2 (imem ack immediate) -> R1=5, retire pulses at cycles 4/8/12 after reset release, pc=3.
- DATA_W=8: li R1=3; shl R1 x5 (R1=0x60); li R2=3; shl R2 x5 (R2=0x60); add R1,R2 -> R1=0xC0, overflow=1 and still 1 after a later sub of 0x02-0x01.
- sw R1,[R2] with R1=0x5A, R2=0x10, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=1, addr=0x10, wdata=0x5A; subsequent lw R3,[R2] -> R3=0x5A.
- R0=0xFE (-2), pc=5, bne R1,R2 with unequal values -> pc=3. beq with same operands -> pc=6. pc=0xFF non-branch -> pc wraps to 0x00.
- jal R2,R2 with R2=0x20 at pc=7 -> pc=0x20, R2=0x08. halt -> halted=1, imem_req stays 0 for 20 cycles.
- Assert reset during MEM wait (dmem_req=1) -> dmem_req drops asynchronously, pc=0, all registers 0. After release, fetch restarts at address 0.
